// File: rtl/tlk2711_pkg.sv
// Shared constants and state encoding for the TLK2711 receive framer.
package tlk2711_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] K29_7 = 8'hFD;

  localparam logic [7:0] HEAD_0   = 8'hE1;
  localparam logic [7:0] HEAD_1   = 8'h16;
  localparam logic [7:0] HEAD_2   = 8'hEB;
  localparam logic [7:0] HEAD_3   = 8'h90;
  localparam logic [7:0] TX_IND   = 8'h81;
  localparam logic [7:0] FILE_END = 8'h01;

  // Link words as they appear on RXD: upper byte in [15:8].
  localparam logic [15:0] IDLE_WORD  = {D5_6, K28_5};
  localparam logic [15:0] START_WORD = {K28_2, K27_7};
  localparam logic [15:0] END_WORD   = {K29_7, K30_7};
  localparam logic [15:0] HEAD_WORD0 = {HEAD_0, HEAD_1};
  localparam logic [15:0] HEAD_WORD1 = {HEAD_2, HEAD_3};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HEAD0,
    ST_HEAD1,
    ST_FSIGN,
    ST_FNUM,
    ST_DLEN,
    ST_DATA,
    ST_TAIL,
    ST_END
  } rx_state_e;

  function automatic logic is_kpair(input logic msb, input logic lsb,
                                    input logic [15:0] word, input logic [15:0] code);
    return msb && lsb && (word == code);
  endfunction

endpackage

// File: rtl/tlk2711_rx_pack.sv
// Packs 16-bit payload words into DATA_WIDTH beats (first word in the low bits)
// behind a valid/ready output register with overflow detection.
module tlk2711_rx_pack
  import tlk2711_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_soft_reset,
  input  logic                  i_frame_start,
  input  logic                  i_word_valid,
  input  logic                  i_word_last,
  input  logic [15:0]           i_word,
  input  logic                  i_rx_ready,
  output logic                  o_rx_valid,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_last,
  output logic                  o_overflow
);

  localparam int WORDS = DATA_WIDTH / 16;
  localparam int CNT_W = $clog2(WORDS);

  logic [CNT_W-1:0]      slot;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] beat;
  logic                  beat_done;

  // acc is cleared after every beat, so a short final beat is zero-padded.
  always_comb begin
    beat                      = acc;
    beat[{slot, 4'b0000} +: 16] = i_word;
    beat_done                 = i_word_valid && (i_word_last || (slot == CNT_W'(WORDS - 1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot       <= '0;
      acc        <= '0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
      o_rx_last  <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_soft_reset) begin
      slot       <= '0;
      acc        <= '0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
      o_rx_last  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (i_frame_start) begin
        slot <= '0;
        acc  <= '0;
      end else if (i_word_valid) begin
        if (beat_done) begin
          slot <= '0;
          acc  <= '0;
        end else begin
          slot <= slot + 1'b1;
          acc  <= beat;
        end
      end

      // A beat completing while the held one is unaccepted is dropped.
      if (beat_done && o_rx_valid && !i_rx_ready) begin
        o_overflow <= 1'b1;
      end else if (beat_done) begin
        o_rx_valid <= 1'b1;
        o_rx_data  <= beat;
        o_rx_last  <= i_word_last;
      end else if (i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tlk2711_rx_frame.sv
// TLK2711 receive framer: comma sync, frame parsing, payload packing and status.
// Optional tail byte-count check is built when RX_TAIL_CHECK_EN is defined.
module tlk2711_rx_frame
  import tlk2711_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int BODY_WORDS    = 435,
  parameter int SYNC_LOCK_CNT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_soft_reset,
  input  logic                  i_rx_enable,
  input  logic                  i_2711_rkmsb,
  input  logic                  i_2711_rklsb,
  input  logic [15:0]           i_2711_rxd,
  output logic                  o_rx_valid,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_last,
  input  logic                  i_rx_ready,
  output logic                  o_sync_lock,
  output logic [15:0]           o_frame_cnt,
  output logic [15:0]           o_frame_dlen,
  output logic                  o_rx_interrupt,
  output logic                  o_err_head,
  output logic                  o_err_fnum,
  output logic                  o_err_tail,
  output logic                  o_overflow
);

  localparam int LOCK_W = $clog2(SYNC_LOCK_CNT + 1);
  localparam int WCNT_W = $clog2(BODY_WORDS);

  rx_state_e         state, state_nxt;
  logic [LOCK_W-1:0] idle_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic [15:0]       exp_fnum;
  logic              last_flag;
  logic              frame_err;

  logic idle_word, start_word, end_word, k_data, resync;
  logic bad, frame_start, fsign_ld, fnum_ld, dlen_ld, data_word, data_last, end_ok;
  logic frame_good, tail_bad;

  assign idle_word  = !i_2711_rkmsb && i_2711_rklsb && (i_2711_rxd == IDLE_WORD);
  assign start_word = is_kpair(i_2711_rkmsb, i_2711_rklsb, i_2711_rxd, START_WORD);
  assign end_word   = is_kpair(i_2711_rkmsb, i_2711_rklsb, i_2711_rxd, END_WORD);
  assign k_data     = !i_2711_rkmsb && !i_2711_rklsb;
  assign resync     = (state != ST_IDLE) && start_word;
  assign frame_good = end_ok && !frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt    <= '0;
      o_sync_lock <= 1'b0;
    end else if (i_soft_reset) begin
      idle_cnt    <= '0;
      o_sync_lock <= 1'b0;
    end else begin
      if (!idle_word) begin
        idle_cnt <= '0;
      end else if (idle_cnt != LOCK_W'(SYNC_LOCK_CNT)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (idle_word && (idle_cnt == LOCK_W'(SYNC_LOCK_CNT - 1))) begin
        o_sync_lock <= 1'b1;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples the pre-edge value of every other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (i_soft_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef RX_TAIL_CHECK_EN
  logic        tail_ld;
  logic [15:0] byte_cnt;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    bad         = 1'b0;
    frame_start = 1'b0;
    fsign_ld    = 1'b0;
    fnum_ld     = 1'b0;
    dlen_ld     = 1'b0;
    data_word   = 1'b0;
    data_last   = 1'b0;
    end_ok      = 1'b0;
`ifdef RX_TAIL_CHECK_EN
    tail_ld     = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (o_sync_lock && i_rx_enable && start_word) begin
          state_nxt   = ST_HEAD0;
          frame_start = 1'b1;
        end
      end
      ST_HEAD0: if (k_data && (i_2711_rxd == HEAD_WORD0)) state_nxt = ST_HEAD1; else bad = 1'b1;
      ST_HEAD1: if (k_data && (i_2711_rxd == HEAD_WORD1)) state_nxt = ST_FSIGN; else bad = 1'b1;
      ST_FSIGN: begin
        if (k_data && (i_2711_rxd[7:0] == TX_IND)) begin
          fsign_ld  = 1'b1;
          state_nxt = ST_FNUM;
        end else begin
          bad = 1'b1;
        end
      end
      ST_FNUM: begin
        if (k_data) begin
          fnum_ld   = 1'b1;
          state_nxt = ST_DLEN;
        end else begin
          bad = 1'b1;
        end
      end
      ST_DLEN: begin
        if (k_data) begin
          dlen_ld   = 1'b1;
          state_nxt = ST_DATA;
        end else begin
          bad = 1'b1;
        end
      end
      ST_DATA: begin
        if (k_data) begin
          data_word = 1'b1;
          if (word_cnt == WCNT_W'(BODY_WORDS - 1)) begin
            data_last = 1'b1;
            state_nxt = ST_TAIL;
          end
        end else begin
          bad = 1'b1;
        end
      end
      ST_TAIL: begin
        if (k_data) begin
`ifdef RX_TAIL_CHECK_EN
          tail_ld   = 1'b1;
`endif
          state_nxt = ST_END;
        end else begin
          bad = 1'b1;
        end
      end
      ST_END: begin
        if (end_word) begin
          end_ok    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          bad = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (bad) state_nxt = ST_IDLE;
    // A start pair mid-frame is always also a violation; restart on it directly.
    if (resync) begin
      state_nxt   = ST_HEAD0;
      frame_start = 1'b1;
    end
  end

`ifdef RX_TAIL_CHECK_EN
  assign tail_bad = tail_ld && (i_2711_rxd != byte_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      o_err_tail <= 1'b0;
    end else if (i_soft_reset) begin
      byte_cnt   <= '0;
      o_err_tail <= 1'b0;
    end else begin
      if (frame_start) begin
        byte_cnt <= '0;
      end else if (fsign_ld || fnum_ld || dlen_ld || data_word) begin
        byte_cnt <= byte_cnt + 16'd2;
      end
      if (tail_bad) o_err_tail <= 1'b1;
    end
  end
`else
  assign tail_bad   = 1'b0;
  assign o_err_tail = 1'b0;
`endif

  // Overflow is a downstream delivery fault and does not disqualify a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt       <= '0;
      last_flag      <= 1'b0;
      frame_err      <= 1'b0;
      exp_fnum       <= '0;
      o_frame_dlen   <= '0;
      o_frame_cnt    <= '0;
      o_rx_interrupt <= 1'b0;
      o_err_head     <= 1'b0;
      o_err_fnum     <= 1'b0;
    end else if (i_soft_reset) begin
      word_cnt       <= '0;
      last_flag      <= 1'b0;
      frame_err      <= 1'b0;
      exp_fnum       <= '0;
      o_frame_dlen   <= '0;
      o_frame_cnt    <= '0;
      o_rx_interrupt <= 1'b0;
      o_err_head     <= 1'b0;
      o_err_fnum     <= 1'b0;
    end else begin
      o_rx_interrupt <= frame_good && last_flag;
      if (frame_start) begin
        word_cnt  <= '0;
        frame_err <= 1'b0;
      end else if (data_word) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (fsign_ld) last_flag <= (i_2711_rxd[15:8] == FILE_END);
      if (fnum_ld) begin
        exp_fnum <= i_2711_rxd + 16'd1;
        if (i_2711_rxd != exp_fnum) begin
          o_err_fnum <= 1'b1;
          frame_err  <= 1'b1;
        end
      end
      if (dlen_ld) o_frame_dlen <= i_2711_rxd;
      if (tail_bad) frame_err <= 1'b1;
      if (bad) o_err_head <= 1'b1;
      if (frame_good) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
        if (last_flag) exp_fnum <= '0;
      end
    end
  end

  tlk2711_rx_pack #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pack (
    .clk          (clk),
    .rst          (rst),
    .i_soft_reset (i_soft_reset),
    .i_frame_start(frame_start),
    .i_word_valid (data_word),
    .i_word_last  (data_last),
    .i_word       (i_2711_rxd),
    .i_rx_ready   (i_rx_ready),
    .o_rx_valid   (o_rx_valid),
    .o_rx_data    (o_rx_data),
    .o_rx_last    (o_rx_last),
    .o_overflow   (o_overflow)
  );

endmodule

// File: tb/tb_tlk2711_rx_frame.sv
// Directed bench for tlk2711_rx_frame: table of whole frames plus hand-written
// sync-lock, interrupt-timing and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_tlk2711_rx_frame;

`ifdef RX_TAIL_CHECK_EN
  localparam int TC = 1;
`else
  localparam int TC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_soft_reset = 1'b0;
  logic        i_rx_enable = 1'b1;
  logic        i_2711_rkmsb = 1'b0;
  logic        i_2711_rklsb = 1'b1;
  logic [15:0] i_2711_rxd = 16'hC5BC;
  logic        i_rx_ready = 1'b1;
  logic        o_rx_valid;
  logic [63:0] o_rx_data;
  logic        o_rx_last;
  logic        o_sync_lock;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_frame_dlen;
  logic        o_rx_interrupt;
  logic        o_err_head;
  logic        o_err_fnum;
  logic        o_err_tail;
  logic        o_overflow;

  tlk2711_rx_frame dut (
    .clk           (clk),
    .rst           (rst),
    .i_soft_reset  (i_soft_reset),
    .i_rx_enable   (i_rx_enable),
    .i_2711_rkmsb  (i_2711_rkmsb),
    .i_2711_rklsb  (i_2711_rklsb),
    .i_2711_rxd    (i_2711_rxd),
    .o_rx_valid    (o_rx_valid),
    .o_rx_data     (o_rx_data),
    .o_rx_last     (o_rx_last),
    .i_rx_ready    (i_rx_ready),
    .o_sync_lock   (o_sync_lock),
    .o_frame_cnt   (o_frame_cnt),
    .o_frame_dlen  (o_frame_dlen),
    .o_rx_interrupt(o_rx_interrupt),
    .o_err_head    (o_err_head),
    .o_err_fnum    (o_err_fnum),
    .o_err_tail    (o_err_tail),
    .o_overflow    (o_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Free-running cycle index and beat/interrupt monitor (sampled on negedge).
  int          cyc = 0;
  int          end_cyc = 0;
  int          beat_cnt, last_cnt, irq_cnt, irq_cyc;
  logic [63:0] first_beat, final_beat;
  logic        final_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_rx_valid && i_rx_ready) begin
        if (beat_cnt == 0) first_beat = o_rx_data;
        final_beat = o_rx_data;
        final_last = o_rx_last;
        beat_cnt++;
        if (o_rx_last) last_cnt++;
      end
      if (o_rx_interrupt) begin
        irq_cnt++;
        irq_cyc = cyc;
      end
    end
  end

  typedef struct {
    logic [15:0] fnum;
    logic        fe;
    logic [15:0] head1;
    logic [15:0] tail;
    logic [15:0] dlen;
    logic        stall;
    int          beats;
    logic [15:0] cnt;
    logic [15:0] dlen_exp;
    logic        e_head;
    logic        e_fnum;
    logic        e_tail;
    logic        ovf;
    int          irqs;
  } vec_t;

  vec_t tbl [9];

  task automatic put(input logic msb, input logic lsb, input logic [15:0] d);
    i_2711_rkmsb = msb;
    i_2711_rklsb = lsb;
    i_2711_rxd   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 1'b1, 16'hC5BC);
  endtask

  task automatic send_frame(input vec_t v);
    put(1'b1, 1'b1, 16'h5CFB);
    put(1'b0, 1'b0, 16'hE116);
    put(1'b0, 1'b0, v.head1);
    put(1'b0, 1'b0, {(v.fe ? 8'h01 : 8'h00), 8'h81});
    put(1'b0, 1'b0, v.fnum);
    put(1'b0, 1'b0, v.dlen);
    for (int k = 0; k < 435; k++) begin
      if (v.stall && k == 4)  i_rx_ready = 1'b0;
      if (v.stall && k == 10) i_rx_ready = 1'b1;
      put(1'b0, 1'b0, 16'(k));
    end
    put(1'b0, 1'b0, v.tail);
    end_cyc = cyc;
    put(1'b1, 1'b1, 16'hFDFE);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(o_rx_valid), 64'd0);
    check({tag, "_data"},  o_rx_data, 64'd0);
    check({tag, "_last"},  64'(o_rx_last), 64'd0);
    check({tag, "_lock"},  64'(o_sync_lock), 64'd0);
    check({tag, "_fcnt"},  64'(o_frame_cnt), 64'd0);
    check({tag, "_dlen"},  64'(o_frame_dlen), 64'd0);
    check({tag, "_irq"},   64'(o_rx_interrupt), 64'd0);
    check({tag, "_ehead"}, 64'(o_err_head), 64'd0);
    check({tag, "_efnum"}, 64'(o_err_fnum), 64'd0);
    check({tag, "_etail"}, 64'(o_err_tail), 64'd0);
    check({tag, "_ovf"},   64'(o_overflow), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //            fnum fe head1     tail  dlen      stl beats cnt            dlen_exp  eh ef et       ovf irq
    tbl[0] = '{16'd0, 1'b0, 16'hEB90, 16'd876, 16'h0300, 1'b0, 109, 16'd1,        16'h0300, 1'b0, 1'b0, 1'b0,     1'b0, 0};
    tbl[1] = '{16'd1, 1'b0, 16'hEB90, 16'd876, 16'h0301, 1'b0, 109, 16'd2,        16'h0301, 1'b0, 1'b0, 1'b0,     1'b0, 0};
    tbl[2] = '{16'd2, 1'b1, 16'hEB90, 16'd876, 16'h0302, 1'b0, 109, 16'd3,        16'h0302, 1'b0, 1'b0, 1'b0,     1'b0, 1};
    tbl[3] = '{16'd0, 1'b0, 16'hEB90, 16'd876, 16'h0303, 1'b0, 109, 16'd4,        16'h0303, 1'b0, 1'b0, 1'b0,     1'b0, 0};
    tbl[4] = '{16'd2, 1'b0, 16'hEB90, 16'd876, 16'h0304, 1'b0, 109, 16'd4,        16'h0304, 1'b0, 1'b1, 1'b0,     1'b0, 0};
    tbl[5] = '{16'd3, 1'b0, 16'hEB91, 16'd876, 16'h0305, 1'b0, 0,   16'd4,        16'h0304, 1'b1, 1'b1, 1'b0,     1'b0, 0};
    tbl[6] = '{16'd3, 1'b0, 16'hEB90, 16'd876, 16'h0306, 1'b0, 109, 16'd5,        16'h0306, 1'b1, 1'b1, 1'b0,     1'b0, 0};
    tbl[7] = '{16'd4, 1'b0, 16'hEB90, 16'd875, 16'h0307, 1'b0, 109, 16'(6 - TC),  16'h0307, 1'b1, 1'b1, 1'(TC),   1'b0, 0};
    tbl[8] = '{16'd5, 1'b0, 16'hEB90, 16'd876, 16'h0308, 1'b1, 108, 16'(7 - TC),  16'h0308, 1'b1, 1'b1, 1'(TC),   1'b1, 0};

    beat_cnt = 0; last_cnt = 0; irq_cnt = 0; irq_cyc = 0;
    first_beat = '0; final_beat = '0; final_last = 1'b0;

    #1;
    check_all_zero("reset");
    #20;
    @(posedge clk);
    #1;
    rst = 1'b0;

    idles(15);
    check("lock_after_15_idles", 64'(o_sync_lock), 64'd0);
    idles(1);
    check("lock_after_16_idles", 64'(o_sync_lock), 64'd1);
    idles(16);

    for (int i = 0; i < 9; i++) begin
      beat_cnt = 0; last_cnt = 0; irq_cnt = 0; irq_cyc = 0;
      send_frame(tbl[i]);
      idles(8);
      check($sformatf("f%0d_beats", i), 64'(beat_cnt), 64'(tbl[i].beats));
      check($sformatf("f%0d_last_cnt", i), 64'(last_cnt), (tbl[i].beats > 0) ? 64'd1 : 64'd0);
      check($sformatf("f%0d_frame_cnt", i), 64'(o_frame_cnt), 64'(tbl[i].cnt));
      check($sformatf("f%0d_dlen", i), 64'(o_frame_dlen), 64'(tbl[i].dlen_exp));
      check($sformatf("f%0d_err_head", i), 64'(o_err_head), 64'(tbl[i].e_head));
      check($sformatf("f%0d_err_fnum", i), 64'(o_err_fnum), 64'(tbl[i].e_fnum));
      check($sformatf("f%0d_err_tail", i), 64'(o_err_tail), 64'(tbl[i].e_tail));
      check($sformatf("f%0d_overflow", i), 64'(o_overflow), 64'(tbl[i].ovf));
      check($sformatf("f%0d_irq_cnt", i), 64'(irq_cnt), 64'(tbl[i].irqs));
      if (tbl[i].beats > 0) begin
        check($sformatf("f%0d_first_beat", i), first_beat, 64'h0003_0002_0001_0000);
        check($sformatf("f%0d_final_beat", i), final_beat, 64'h0000_01B2_01B1_01B0);
        check($sformatf("f%0d_final_last", i), 64'(final_last), 64'd1);
      end
      if (tbl[i].irqs > 0) begin
        check($sformatf("f%0d_irq_cycle", i), 64'(irq_cyc), 64'(end_cyc + 1));
      end
    end

    // Partial frame, then asynchronous reset between clock edges.
    put(1'b1, 1'b1, 16'h5CFB);
    put(1'b0, 1'b0, 16'hE116);
    put(1'b0, 1'b0, 16'hEB90);
    put(1'b0, 1'b0, 16'h0081);
    put(1'b0, 1'b0, 16'd6);
    put(1'b0, 1'b0, 16'h0309);
    for (int k = 0; k < 20; k++) put(1'b0, 1'b0, 16'(k));
    check("pre_reset_frame_cnt", 64'(o_frame_cnt), 64'(7 - TC));
    check("pre_reset_dlen", 64'(o_frame_dlen), 64'h0309);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #10;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
